sprite_rom_arbiter: RTL
=======================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one 64x32x12 sprite ROM (2-stage: registered address, then registered data)
//  between N_REQ sprite requesters, e.g. ghost/zombie row renderers.
//  Accepts row-burst requests (start x, y, beat count) and grants them round-robin.
//  Drives the ROM x/y/enable and returns each pixel tagged with requester id and a last-beat flag.
// PARAMETERS
//  N_REQ      4       number of requesters (2..8)
//  ID_W       2       width of rsp_id; must be >= clog2(N_REQ)
//  ROM_LAT    2       cycles from rom_x/rom_y issue to rom_color valid
//  TRANSP_KEY 12'h000 transparent colour key (used only with SPRITE_ARB_TRANSP_EN)
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          synchronous reset, active low
//  req         in   N_REQ      per-requester burst request, level, held until gnt
//  req_x       in   6*N_REQ    start x, slice i = req_x[6i+5:6i]
//  req_y       in   5*N_REQ    row y, slice i = req_y[5i+4:5i]
//  req_len     in   6*N_REQ    beats-1 (0..63)
//  gnt         out  N_REQ      one-hot 1-cycle pulse: burst accepted, fields latched
//  busy        out  1          state != IDLE
//  rom_en      out  1          ROM enable (video_on of the ROM)
//  rom_x       out  6          ROM column
//  rom_y       out  5          ROM row
//  rom_color   in   12         ROM data
//  rsp_valid   out  1          rsp_color valid this cycle
//  rsp_id      out  ID_W       requester owning this pixel
//  rsp_color   out  12         pixel colour (= rom_color)
//  rsp_last    out  1          final pixel of the burst
//  rsp_transp  out  1          only with SPRITE_ARB_TRANSP_EN
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=N_REQ-1 (requester 0 wins first).
//   All outputs 0 one cycle after rst_n low; all in-flight tags discarded.
//  FSM: IDLE, BURST, DRAIN.
//   IDLE: any req -> gnt winner, latch x/y/len/id -> BURST.
//   BURST: issue one beat per cycle (rom_en=1, rom_x=cur_x, rom_y=lat_y);
//    cur_x increments mod 64 (63 -> 0, y unchanged).
//   On last beat: if any req pending, gnt next winner in that same cycle and stay
//    in BURST (no bubble). Otherwise -> DRAIN.
//   DRAIN: rom_en held 1 for ROM_LAT-1 cycles so the ROM data stage completes, no
//    issue; a req seen in DRAIN is granted and goes to BURST; else -> IDLE.
//  rom_en = (state != IDLE); rom_x/rom_y hold last value when not issuing.
//  Arbitration: round-robin, search from rr_ptr+1 upward with wrap.
//   rr_ptr <= winner on each gnt. At most one gnt bit per cycle.
//  Timing: gnt at cycle g; beat k issued at g+1+k; its rsp at g+1+k+ROM_LAT.
//  Tag pipe: ROM_LAT-deep shift of {valid,id,last} aligned to rom_color;
//   rsp_valid, rsp_id and rsp_last come from the tag pipe.
//  Beats per burst = req_len+1; len=0 gives 1 beat with rsp_last=1.
//  rsp has no backpressure; consumers must accept every rsp_valid beat.
//  req dropped before gnt: request is withdrawn, no side effect.
//  req held after gnt: treated as a new request.
// CONFIGURATION
//  SPRITE_ARB_TRANSP_EN defined:
//   - rsp_transp port exists, = rsp_valid && (rom_color == TRANSP_KEY).
//   - transparent pixels still deliver rsp_valid.
//  Undefined: no rsp_transp port and no compare logic; all else identical.
// TESTING
//  1. req[0], x=5, y=3, len=3 from cycle 0 -> gnt[0] cycle 0; rom_x 5,6,7,8 @ y=3 cycles 1-4;
//     rsp_valid cycles 3-6, id=0, rsp_last only cycle 6; IDLE by cycle 6.
//  2. req[1], x=62, y=31, len=3 -> rom_x 62,63,0,1; rom_y stays 31.
//  3. req=4'b1111 held, len=0 each -> gnt order 0,1,2,3,0; one beat every cycle;
//     rsp_id 0,1,2,3,0 with no gap.
//  4. rst_n low mid-burst (beat 2 of 8) -> next cycle rsp_valid=0, rom_en=0, gnt=0, busy=0;
//     then req[2] and req[0] together -> gnt[0] first.
//  5. ROM preloaded with addr {y,x} -> rsp_color == {y,x} for every beat.
//     With SPRITE_ARB_TRANSP_EN and a 12'h000 pixel: rsp_transp=1 on that beat only.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one 2-stage sprite ROM between N_REQ row-burst requesters.
// Define SPRITE_ARB_TRANSP_EN to add the rsp_transp colour-key flag and the TRANSP_KEY parameter.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int ROM_LAT = 2
`ifdef SPRITE_ARB_TRANSP_EN
  ,
  parameter logic [11:0] TRANSP_KEY = 12'h000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [6*N_REQ-1:0] req_x,
  input  logic [5*N_REQ-1:0] req_y,
  input  logic [6*N_REQ-1:0] req_len,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               rom_en,
  output logic [5:0]         rom_x,
  output logic [4:0]         rom_y,
  input  logic [11:0]        rom_color,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [11:0]        rsp_color,
  output logic               rsp_last
`ifdef SPRITE_ARB_TRANSP_EN
  ,
  output logic               rsp_transp
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] win_id;
  logic [5:0]      x_q, x_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [4:0]      y_q, y_d;
  logic [7:0]      drain_q, drain_d;
  logic            win_found;
  logic            grant_en;
  logic            issue;
  logic            last_beat;
  int              win_int;

  logic            tag_vld_q  [ROM_LAT];
  logic [ID_W-1:0] tag_id_q   [ROM_LAT];
  logic            tag_last_q [ROM_LAT];

  // Lowest requester above rr_ptr wins; otherwise lowest at or below it (wrap).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j <= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_id    = ID_W'(j);
      end
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_id    = ID_W'(j);
      end
    end
  end

  assign win_int = int'(win_id);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    last_beat = 1'b0;
    grant_en  = 1'b0;
    case (state_q)
      IDLE: grant_en = win_found;
      BURST: begin
        issue     = 1'b1;
        last_beat = (cnt_q == 6'd0);
        if (!last_beat) begin
          x_d   = x_q + 6'd1;
          cnt_d = cnt_q - 6'd1;
        end else if (win_found) begin
          grant_en = 1'b1;
        end else if (ROM_LAT > 1) begin
          state_d = DRAIN;
          drain_d = 8'(ROM_LAT - 2);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (win_found) begin
          grant_en = 1'b1;
        end else if (drain_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_en) begin
      state_d  = BURST;
      rr_ptr_d = win_id;
      id_d     = win_id;
      x_d      = req_x[6*win_int +: 6];
      y_d      = req_y[5*win_int +: 5];
      cnt_d    = req_len[6*win_int +: 6];
    end
  end

  // gnt is combinational so a new burst can start on the same cycle as the previous last beat.
  assign gnt    = (grant_en && rst_n) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id) : '0;
  assign busy   = (state_q != IDLE);
  assign rom_en = (state_q != IDLE);
  assign rom_x  = x_q;
  assign rom_y  = y_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(N_REQ - 1);
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
    end
  end

  // Tag pipe matches the ROM address+data register stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld_q[i]  <= 1'b0;
        tag_id_q[i]   <= '0;
        tag_last_q[i] <= 1'b0;
      end
    end else begin
      tag_vld_q[0]  <= issue;
      tag_id_q[0]   <= issue ? id_q : '0;
      tag_last_q[0] <= last_beat;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_id_q[i]   <= tag_id_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  assign rsp_valid = tag_vld_q[ROM_LAT-1];
  assign rsp_id    = tag_id_q[ROM_LAT-1];
  assign rsp_last  = tag_last_q[ROM_LAT-1];
  // Colour is forced to zero between beats so every output is quiet while idle or in reset.
  assign rsp_color = rsp_valid ? rom_color : 12'h000;

`ifdef SPRITE_ARB_TRANSP_EN
  assign rsp_transp = rsp_valid && (rom_color == TRANSP_KEY);
`endif

endmodule
